// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined 74181-style ALU (16 logic + 16 arithmetic functions) with valid/ready.
// Define ALU_OVF_EN to register signed overflow on ovf; otherwise ovf is tied to 0.
module alu_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       sel,
  input  logic             M,
  input  logic             Cn,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             cout,
  output logic             zero,
  output logic             aeqb,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  function automatic logic [WIDTH-1:0] logic_fn(input logic [3:0] s, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (s)
      4'd0:    r = ~a;
      4'd1:    r = ~(a | b);
      4'd2:    r = ~a & b;
      4'd3:    r = ZERO;
      4'd4:    r = ~(a & b);
      4'd5:    r = ~b;
      4'd6:    r = a ^ b;
      4'd7:    r = a & ~b;
      4'd8:    r = ~a | b;
      4'd9:    r = ~(a ^ b);
      4'd10:   r = b;
      4'd11:   r = a & b;
      4'd12:   r = ONES;
      4'd13:   r = a | ~b;
      4'd14:   r = a | b;
      4'd15:   r = a;
      default: r = ZERO;
    endcase
    return r;
  endfunction

  // Returns {X, Y} addends for the arithmetic function table.
  function automatic logic [2*WIDTH-1:0] arith_ops(input logic [3:0] s, input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] r;
    case (s)
      4'd0:    r = {a, ZERO};
      4'd1:    r = {a | b, ZERO};
      4'd2:    r = {a | ~b, ZERO};
      4'd3:    r = {ZERO, ONES};
      4'd4:    r = {a, a & ~b};
      4'd5:    r = {a | b, a & ~b};
      4'd6:    r = {a, ~b};
      4'd7:    r = {a & ~b, ONES};
      4'd8:    r = {a, a & b};
      4'd9:    r = {a, b};
      4'd10:   r = {a | ~b, a & b};
      4'd11:   r = {a & b, ONES};
      4'd12:   r = {a, a};
      4'd13:   r = {a | b, a};
      4'd14:   r = {a | ~b, a};
      4'd15:   r = {a, ONES};
      default: r = {ZERO, ZERO};
    endcase
    return r;
  endfunction

  logic             s1_valid_r;
  logic [3:0]       s1_sel_r;
  logic             s1_m_r;
  logic             s1_cn_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;

  logic             out_valid_r;
  logic [WIDTH-1:0] f_r;
  logic             cout_r;
  logic             zero_r;
  logic             aeqb_r;

  logic             s2_adv_s;
  logic             s1_adv_s;
  logic [WIDTH-1:0] x_s;
  logic [WIDTH-1:0] y_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] f_next_s;
  logic             cout_next_s;

  assign s2_adv_s  = !out_valid_r || out_ready;
  assign s1_adv_s  = !s1_valid_r || s2_adv_s;
  assign in_ready  = s1_adv_s && !flush;
  assign out_valid = out_valid_r;
  assign F         = f_r;
  assign cout      = cout_r;
  assign zero      = zero_r;
  assign aeqb      = aeqb_r;

  // Result datapath computed from the stage-1 operands.
  always_comb begin
    {x_s, y_s}  = arith_ops(s1_sel_r, s1_a_r, s1_b_r);
    sum_s       = {1'b0, x_s} + {1'b0, y_s} + {{WIDTH{1'b0}}, ~s1_cn_r};
    f_next_s    = sum_s[WIDTH-1:0];
    cout_next_s = 1'b0;
    if (s1_m_r) begin
      f_next_s    = logic_fn(s1_sel_r, s1_a_r, s1_b_r);
      cout_next_s = 1'b0;
    end else begin
      f_next_s    = sum_s[WIDTH-1:0];
      cout_next_s = sum_s[WIDTH];
    end
  end

  // Stage 1: operand capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_sel_r   <= 4'd0;
      s1_m_r     <= 1'b0;
      s1_cn_r    <= 1'b0;
      s1_a_r     <= ZERO;
      s1_b_r     <= ZERO;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_sel_r <= sel;
        s1_m_r   <= M;
        s1_cn_r  <= Cn;
        s1_a_r   <= A;
        s1_b_r   <= B;
      end
    end
  end

  // Stage 2: result and flags; payload only moves when a valid bundle advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      f_r         <= ZERO;
      cout_r      <= 1'b0;
      zero_r      <= 1'b0;
      aeqb_r      <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (s2_adv_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        f_r    <= f_next_s;
        cout_r <= cout_next_s;
        zero_r <= (f_next_s == ZERO);
        aeqb_r <= (f_next_s == ONES);
      end
    end
  end

`ifdef ALU_OVF_EN
  logic ovf_r;
  logic ovf_next_s;

  // Signed overflow: like-signed addends producing a result of the other sign.
  always_comb begin
    ovf_next_s = 1'b0;
    if (s1_m_r) begin
      ovf_next_s = 1'b0;
    end else begin
      ovf_next_s = (x_s[WIDTH-1] == y_s[WIDTH-1]) && (f_next_s[WIDTH-1] != x_s[WIDTH-1]);
    end
  end

  // Overflow flag travels with F in stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (flush) begin
      ovf_r <= ovf_r;
    end else if (s2_adv_s && s1_valid_r) begin
      ovf_r <= ovf_next_s;
    end
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: 4-bit directed cases plus 8-bit randomized scoreboard runs.
module tb_alu_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       d8_flush, d8_in_valid, d8_in_ready, d8_M, d8_Cn, d8_out_valid, d8_out_ready;
  logic       d8_cout, d8_zero, d8_aeqb, d8_ovf;
  logic [3:0] d8_sel;
  logic [7:0] d8_A, d8_B, d8_F;

  logic       d4_flush, d4_in_valid, d4_in_ready, d4_M, d4_Cn, d4_out_valid, d4_out_ready;
  logic       d4_cout, d4_zero, d4_aeqb, d4_ovf;
  logic [3:0] d4_sel;
  logic [3:0] d4_A, d4_B, d4_F;

  int total = 0;
  int bad = 0;
  logic [9:0] q8[$];
  logic       exp_ovf_flag;

  alu_pipe #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .flush(d8_flush), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
    .sel(d8_sel), .M(d8_M), .Cn(d8_Cn), .A(d8_A), .B(d8_B), .out_valid(d8_out_valid),
    .out_ready(d8_out_ready), .F(d8_F), .cout(d8_cout), .zero(d8_zero), .aeqb(d8_aeqb), .ovf(d8_ovf)
  );

  alu_pipe #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(d4_flush), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
    .sel(d4_sel), .M(d4_M), .Cn(d4_Cn), .A(d4_A), .B(d4_B), .out_valid(d4_out_valid),
    .out_ready(d4_out_ready), .F(d4_F), .cout(d4_cout), .zero(d4_zero), .aeqb(d4_aeqb), .ovf(d4_ovf)
  );

  // Reference: {ovf, cout, F} from the function tables using plain integer arithmetic.
  function automatic logic [9:0] ref_alu(input int w, input logic [3:0] s, input logic m,
                                         input logic cn, input logic [7:0] a, input logic [7:0] b);
    longint unsigned mask, ua, ub, na, nb, x, y, sum, f;
    logic c, o;
    mask = (64'd1 << w) - 64'd1;
    ua = a & mask; ub = b & mask; na = ~ua & mask; nb = ~ub & mask;
    x = 0; y = 0; c = 1'b0; o = 1'b0; f = 0;
    if (m) begin
      case (s)
        0: f = na;             1: f = ~(ua | ub);     2: f = na & ub;        3: f = 0;
        4: f = ~(ua & ub);     5: f = nb;             6: f = ua ^ ub;        7: f = ua & nb;
        8: f = na | ub;        9: f = ~(ua ^ ub);     10: f = ub;            11: f = ua & ub;
        12: f = mask;          13: f = ua | nb;       14: f = ua | ub;       default: f = ua;
      endcase
      f = f & mask;
    end else begin
      case (s)
        0: begin x = ua; y = 0; end            1: begin x = ua | ub; y = 0; end
        2: begin x = ua | nb; y = 0; end       3: begin x = 0; y = mask; end
        4: begin x = ua; y = ua & nb; end      5: begin x = ua | ub; y = ua & nb; end
        6: begin x = ua; y = nb; end           7: begin x = ua & nb; y = mask; end
        8: begin x = ua; y = ua & ub; end      9: begin x = ua; y = ub; end
        10: begin x = ua | nb; y = ua & ub; end 11: begin x = ua & ub; y = mask; end
        12: begin x = ua; y = ua; end          13: begin x = ua | ub; y = ua; end
        14: begin x = ua | nb; y = ua; end     default: begin x = ua; y = mask; end
      endcase
      sum = x + y + (cn ? 64'd0 : 64'd1);
      f = sum & mask;
      c = sum[w];
      o = (x[w-1] == y[w-1]) && (f[w-1] != x[w-1]);
    end
`ifndef ALU_OVF_EN
    o = 1'b0;
`endif
    return {o, c, f[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_op8();
    d8_sel = 4'($urandom_range(0, 15));
    d8_M   = 1'($urandom);
    d8_Cn  = 1'($urandom);
    d8_A   = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
    d8_B   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
  endtask

  task automatic test_reset();
    logic [9:0] e;
    rst = 1'b1;
    #12;
    total++;
    if ({d8_out_valid, d8_F, d8_cout, d8_zero, d8_aeqb, d8_ovf, d8_in_ready, d4_out_valid} !== {1'b0, 8'h00, 5'b00001, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got ov=%b F=%h c=%b z=%b e=%b o=%b ir=%b ov4=%b, want 0 00 0 0 0 0 1 0",
               d8_out_valid, d8_F, d8_cout, d8_zero, d8_aeqb, d8_ovf, d8_in_ready, d4_out_valid);
    end
    @(negedge clk); rst = 1'b0;
    d8_out_ready = 1'b0; d8_in_valid = 1'b1; d8_M = 1'b0; d8_Cn = 1'b1; d8_sel = 4'd9;
    d8_A = 8'h01; d8_B = 8'h02;
    tick();
    d8_A = 8'h10;
    tick();
    e = ref_alu(8, 4'd9, 1'b0, 1'b1, 8'h01, 8'h02);
    total++;
    if (d8_out_valid !== 1'b1 || d8_F !== e[7:0]) begin
      bad++;
      $display("FAIL reset_inflight_setup: got ov=%b F=%h, want 1 %h", d8_out_valid, d8_F, e[7:0]);
    end
    d8_in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if (d8_out_valid !== 1'b0 || d8_F !== 8'h00) begin
      bad++;
      $display("FAIL reset_async: got ov=%b F=%h, want 0 00", d8_out_valid, d8_F);
    end
    @(negedge clk); rst = 1'b0; d8_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (d8_out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_no_stale: cycle %0d got out_valid=%b, want 0", i, d8_out_valid);
      end
    end
  endtask

  task automatic test_arith4();
    logic [3:0] sels[3] = '{4'd9, 4'd6, 4'd6};
    logic       cns[3]  = '{1'b0, 1'b0, 1'b1};
    logic [3:0] as[3]   = '{4'hF, 4'h5, 4'h5};
    logic [3:0] bs[3]   = '{4'h1, 4'h5, 4'h5};
    logic [3:0] fs[3]   = '{4'h1, 4'h0, 4'hF};
    logic       cs[3]   = '{1'b1, 1'b1, 1'b0};
    d4_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d4_in_valid = 1'b1; d4_M = 1'b0; d4_sel = sels[i]; d4_Cn = cns[i]; d4_A = as[i]; d4_B = bs[i];
      tick();
      d4_in_valid = 1'b0;
      total++;
      if (d4_out_valid !== 1'b0) begin
        bad++;
        $display("FAIL arith4_latency%0d: got out_valid=%b after 1 cycle, want 0", i, d4_out_valid);
      end
      tick();
      total++;
      if ({d4_out_valid, d4_F, d4_cout, d4_zero, d4_aeqb, d4_ovf} !==
          {1'b1, fs[i], cs[i], (fs[i] == 4'h0), (fs[i] == 4'hF), 1'b0}) begin
        bad++;
        $display("FAIL arith4_case%0d: got ov=%b F=%h c=%b z=%b e=%b o=%b, want 1 %h %b %b %b 0",
                 i, d4_out_valid, d4_F, d4_cout, d4_zero, d4_aeqb, d4_ovf,
                 fs[i], cs[i], (fs[i] == 4'h0), (fs[i] == 4'hF));
      end
      tick();
    end
  endtask

  task automatic test_logic8();
    logic [9:0] e;
    d8_out_ready = 1'b1; d8_flush = 1'b0;
    for (int s = 0; s < 16; s++) begin
      d8_in_valid = 1'b1; d8_M = 1'b1; d8_Cn = 1'($urandom); d8_sel = 4'(s);
      d8_A = 8'hA5; d8_B = 8'h3C;
      e = ref_alu(8, 4'(s), 1'b1, d8_Cn, 8'hA5, 8'h3C);
      tick();
      d8_in_valid = 1'b0;
      tick();
      total++;
      if ({d8_out_valid, d8_F, d8_cout, d8_zero, d8_aeqb} !== {1'b1, e[7:0], 1'b0, (e[7:0] == 8'h00), (e[7:0] == 8'hFF)}) begin
        bad++;
        $display("FAIL logic8_sel%0d: got ov=%b F=%h c=%b z=%b e=%b, want 1 %h 0", s,
                 d8_out_valid, d8_F, d8_cout, d8_zero, d8_aeqb, e[7:0]);
      end
      if (s == 6) begin
        total++;
        if (d8_F !== 8'h99) begin
          bad++;
          $display("FAIL logic8_xor: got F=%h, want 99", d8_F);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [9:0] e;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_f = 8'h00;
    q8.delete();
    d8_flush = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rand_op8();
      d8_in_valid  = ($urandom_range(0, 3) != 0);
      d8_out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (prev_stall) begin
        total++;
        if (d8_out_valid !== 1'b1 || d8_F !== prev_f) begin
          bad++;
          $display("FAIL random_hold: got ov=%b F=%h, want 1 %h", d8_out_valid, d8_F, prev_f);
        end
      end
      if (d8_out_valid && d8_out_ready) begin
        total++;
        if (q8.size() == 0) begin
          bad++;
          $display("FAIL random_extra: got F=%h, want no result", d8_F);
        end else begin
          e = q8.pop_front();
          if ({d8_ovf, d8_cout, d8_F, d8_zero, d8_aeqb} !== {e, (e[7:0] == 8'h00), (e[7:0] == 8'hFF)}) begin
            bad++;
            $display("FAIL random_result: got o=%b c=%b F=%h z=%b e=%b, want %b %b %h", d8_ovf, d8_cout,
                     d8_F, d8_zero, d8_aeqb, e[9], e[8], e[7:0]);
          end
        end
      end
      if (d8_in_valid && d8_in_ready) q8.push_back(ref_alu(8, d8_sel, d8_M, d8_Cn, d8_A, d8_B));
      prev_stall = d8_out_valid && !d8_out_ready;
      prev_f = d8_F;
      tick();
    end
    d8_in_valid = 1'b0; d8_out_ready = 1'b1;
    for (int i = 0; i < 10 && q8.size() != 0; i++) begin
      #1;
      if (d8_out_valid) begin
        e = q8.pop_front();
        total++;
        if (d8_F !== e[7:0] || d8_cout !== e[8]) begin
          bad++;
          $display("FAIL random_drain: got F=%h c=%b, want %h %b", d8_F, d8_cout, e[7:0], e[8]);
        end
      end
      tick();
    end
    total++;
    if (q8.size() != 0) begin
      bad++;
      $display("FAIL random_lost: got %0d results missing, want 0", q8.size());
    end
  endtask

  task automatic test_backpressure();
    logic [21:0] ops[5];
    logic [9:0]  e;
    int idx = 0;
    int got = 0;
    q8.delete();
    for (int i = 0; i < 5; i++) ops[i] = 22'($urandom);
    d8_out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      d8_in_valid = (idx < 5);
      {d8_sel, d8_M, d8_Cn, d8_A, d8_B} = ops[idx];
      #1;
      if (c >= 2) begin
        total++;
        if (d8_in_ready !== 1'b0 || d8_out_valid !== 1'b1 || d8_F !== q8[0][7:0]) begin
          bad++;
          $display("FAIL bp_stall%0d: got ir=%b ov=%b F=%h, want 0 1 %h", c, d8_in_ready,
                   d8_out_valid, d8_F, q8[0][7:0]);
        end
      end
      if (d8_in_valid && d8_in_ready) begin
        q8.push_back(ref_alu(8, d8_sel, d8_M, d8_Cn, d8_A, d8_B));
        idx++;
      end
      tick();
    end
    total++;
    if (idx != 2) begin
      bad++;
      $display("FAIL bp_accepts: got %0d accepted, want 2", idx);
    end
    d8_out_ready = 1'b1;
    for (int c = 0; c < 30 && got < 5; c++) begin
      d8_in_valid = (idx < 5);
      {d8_sel, d8_M, d8_Cn, d8_A, d8_B} = ops[idx < 5 ? idx : 4];
      #1;
      if (d8_out_valid) begin
        total++;
        e = (q8.size() != 0) ? q8.pop_front() : 10'h3FF;
        if ({d8_ovf, d8_cout, d8_F} !== e) begin
          bad++;
          $display("FAIL bp_order%0d: got %h, want %h", got, {d8_ovf, d8_cout, d8_F}, e);
        end
        got++;
      end
      if (d8_in_valid && d8_in_ready) begin
        q8.push_back(ref_alu(8, d8_sel, d8_M, d8_Cn, d8_A, d8_B));
        idx++;
      end
      tick();
    end
    d8_in_valid = 1'b0;
    total++;
    if (got != 5 || q8.size() != 0) begin
      bad++;
      $display("FAIL bp_count: got %0d results (%0d pending), want 5 (0)", got, q8.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] e;
    int sent = 0;
    int got = 0;
    q8.delete();
    d8_out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      rand_op8();
      d8_in_valid = (sent < 10);
      #1;
      if (d8_out_valid) begin
        e = (q8.size() != 0) ? q8.pop_front() : 10'h3FF;
        total++;
        if ({d8_ovf, d8_cout, d8_F} !== e) begin
          bad++;
          $display("FAIL b2b_result%0d: got %h, want %h", got, {d8_ovf, d8_cout, d8_F}, e);
        end
        got++;
      end
      if (d8_in_valid && d8_in_ready) begin
        q8.push_back(ref_alu(8, d8_sel, d8_M, d8_Cn, d8_A, d8_B));
        sent++;
      end
      tick();
    end
    d8_in_valid = 1'b0;
    total++;
    if (sent != 10 || got != 10) begin
      bad++;
      $display("FAIL b2b_throughput: got sent=%0d results=%0d in 12 cycles, want 10 10", sent, got);
    end
  endtask

  task automatic test_flush();
    logic [7:0] f_before;
`ifdef ALU_OVF_EN
    exp_ovf_flag = 1'b1;
`else
    exp_ovf_flag = 1'b0;
`endif
    d8_out_ready = 1'b0; d8_in_valid = 1'b1; d8_M = 1'b0; d8_Cn = 1'b0; d8_sel = 4'd9;
    d8_A = 8'h21; d8_B = 8'h13;
    tick();
    d8_A = 8'h44;
    tick();
    f_before = d8_F;
    d8_flush = 1'b1; d8_A = 8'h55;
    #1;
    total++;
    if (d8_in_ready !== 1'b0 || d8_out_valid !== 1'b1 || f_before !== 8'h35) begin
      bad++;
      $display("FAIL flush_setup: got ir=%b ov=%b F=%h, want 0 1 35", d8_in_ready, d8_out_valid, f_before);
    end
    tick();
    d8_flush = 1'b0;
    total++;
    if (d8_out_valid !== 1'b0 || d8_F !== f_before) begin
      bad++;
      $display("FAIL flush_clear: got ov=%b F=%h, want 0 %h", d8_out_valid, d8_F, f_before);
    end
    d8_out_ready = 1'b1; d8_in_valid = 1'b1; d8_sel = 4'd9; d8_M = 1'b0; d8_Cn = 1'b1;
    d8_A = 8'h7F; d8_B = 8'h01;
    tick();
    d8_in_valid = 1'b0;
    total++;
    if (d8_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_no_ghost: got out_valid=%b one cycle after accept, want 0", d8_out_valid);
    end
    tick();
    total++;
    if ({d8_out_valid, d8_F, d8_cout, d8_ovf} !== {1'b1, 8'h80, 1'b0, exp_ovf_flag}) begin
      bad++;
      $display("FAIL flush_next_op: got ov=%b F=%h c=%b o=%b, want 1 80 0 %b", d8_out_valid, d8_F,
               d8_cout, d8_ovf, exp_ovf_flag);
    end
    tick();
    total++;
    if (d8_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_drained: got out_valid=%b, want 0", d8_out_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    d8_flush = 1'b0; d8_in_valid = 1'b0; d8_M = 1'b0; d8_Cn = 1'b1; d8_out_ready = 1'b1;
    d8_sel = 4'd0; d8_A = 8'h00; d8_B = 8'h00;
    d4_flush = 1'b0; d4_in_valid = 1'b0; d4_M = 1'b0; d4_Cn = 1'b1; d4_out_ready = 1'b1;
    d4_sel = 4'd0; d4_A = 4'h0; d4_B = 4'h0;
    test_reset();
    test_arith4();
    test_logic8();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
